// File: rtl/par2ser_buffer.sv
// par2ser_buffer: ping-pong block buffer that takes LANES coefficients per
// input handshake and streams them out lane 0 first, one word per output
// handshake, with a lane index and a block-end marker.
module par2ser_buffer #(
    parameter  int DATA_W = 13,
    parameter  int LANES  = 8,
    localparam int IDX_W  = $clog2(LANES)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*DATA_W-1:0]   in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_data,
    output logic [IDX_W-1:0]          out_idx,
    output logic                      out_last,
    output logic [1:0]                occupancy
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

    // Storage and control state
    logic [LANES*DATA_W-1:0] r_slot0;
    logic [LANES*DATA_W-1:0] r_slot1;
    logic                    r_wr_ptr;
    logic                    r_rd_ptr;
    logic [IDX_W-1:0]        r_lane_idx;
    logic [1:0]              r_occ;

    // Output registers, loaded with what the next state will present
    logic                    r_out_valid;
    logic [DATA_W-1:0]       r_out_data;
    logic                    r_out_last;

    // Next-state wires
    logic                    w_in_ready;
    logic                    w_accept;
    logic                    w_beat;
    logic                    w_release;
    logic [IDX_W-1:0]        w_idx_nxt;
    logic                    w_rd_nxt;
    logic [1:0]              w_occ_nxt;
    logic [LANES*DATA_W-1:0] w_blk_nxt;
    logic [DATA_W-1:0]       w_data_nxt;

    // Pick one lane out of a flattened block
    function automatic logic [DATA_W-1:0] lane_of(
        input logic [LANES*DATA_W-1:0] blk,
        input logic [IDX_W-1:0]        idx
    );
        lane_of = blk[idx*DATA_W +: DATA_W];
    endfunction

    // Ready depends only on occupancy and reset, never on out_ready
    assign w_in_ready = (r_occ < 2'd2) && !rst;
    assign in_ready   = w_in_ready;

    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_idx    = r_lane_idx;
    assign out_last   = r_out_last;
    assign occupancy  = r_occ;

    // Handshakes, next counters/pointers and the word to present next cycle
    always_comb begin
        w_accept  = in_valid && w_in_ready;
        w_beat    = r_out_valid && out_ready;
        w_release = w_beat && (r_lane_idx == LAST_IDX);

        if (w_release) begin
            w_idx_nxt = '0;
        end else if (w_beat) begin
            w_idx_nxt = r_lane_idx + 1'b1;
        end else begin
            w_idx_nxt = r_lane_idx;
        end

        w_rd_nxt = r_rd_ptr ^ w_release;

        case ({w_accept, w_release})
            2'b10:   w_occ_nxt = r_occ + 2'd1;
            2'b01:   w_occ_nxt = r_occ - 2'd1;
            default: w_occ_nxt = r_occ;
        endcase

        // A block landing in the slot about to be drained must be seen
        // directly from in_data, since the slot write happens on this edge.
        if (w_accept && (r_wr_ptr == w_rd_nxt)) begin
            w_blk_nxt = in_data;
        end else if (w_rd_nxt) begin
            w_blk_nxt = r_slot1;
        end else begin
            w_blk_nxt = r_slot0;
        end

        w_data_nxt = lane_of(w_blk_nxt, w_idx_nxt);
    end

    // State and registered outputs; reset discards both slots entirely
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_slot0     <= '0;
            r_slot1     <= '0;
            r_wr_ptr    <= 1'b0;
            r_rd_ptr    <= 1'b0;
            r_lane_idx  <= '0;
            r_occ       <= 2'd0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
        end else begin
            if (w_accept) begin
                if (r_wr_ptr) begin
                    r_slot1 <= in_data;
                end else begin
                    r_slot0 <= in_data;
                end
            end
            r_wr_ptr    <= r_wr_ptr ^ w_accept;
            r_rd_ptr    <= w_rd_nxt;
            r_lane_idx  <= w_idx_nxt;
            r_occ       <= w_occ_nxt;
            r_out_valid <= (w_occ_nxt != 2'd0);
            r_out_data  <= w_data_nxt;
            r_out_last  <= (w_occ_nxt != 2'd0) && (w_idx_nxt == LAST_IDX);
        end
    end

endmodule

// File: tb/tb_par2ser_buffer.sv
// Testbench for par2ser_buffer: directed table, hand-written corner
// sequences and randomized traffic against a block-queue reference model.
module tb_par2ser_buffer;

    localparam int DW = 13;
    localparam int L  = 8;
    localparam int BW = DW * L;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [BW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [2:0]    out_idx;
    logic          out_last;
    logic [1:0]    occupancy;

    logic          b_in_valid;
    logic          b_in_ready;
    logic [95:0]   b_in_data;
    logic          b_out_valid;
    logic          b_out_ready;
    logic [15:0]   b_out_data;
    logic [2:0]    b_out_idx;
    logic          b_out_last;
    logic [1:0]    b_occupancy;

    int checks   = 0;
    int failures = 0;

    // Reference model: queue of whole blocks plus position in the head block
    logic [BW-1:0] mq[$];
    int            mpos = 0;

    always #5 clk = ~clk;

    par2ser_buffer #(.DATA_W(DW), .LANES(L)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_idx(out_idx), .out_last(out_last), .occupancy(occupancy)
    );

    par2ser_buffer #(.DATA_W(16), .LANES(6)) dut6 (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_idx(b_out_idx), .out_last(b_out_last), .occupancy(b_occupancy)
    );

    typedef struct {
        logic          iv;
        logic [DW-1:0] base;
        logic          ordy;
        logic          ev;
        logic [DW-1:0] ed;
        logic [2:0]    ei;
        logic          el;
        logic [1:0]    eo;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [BW-1:0] mkblk(input logic [DW-1:0] base);
        logic [BW-1:0] r;
        for (int k = 0; k < L; k++) r[k*DW +: DW] = base + DW'(k);
        return r;
    endfunction

    function automatic logic [BW-1:0] rndblk();
        logic [BW-1:0] r;
        for (int k = 0; k < L; k++) r[k*DW +: DW] = DW'($urandom);
        return r;
    endfunction

    task automatic check_model();
        chk("occupancy", 32'(occupancy), 32'(mq.size()));
        chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
        chk("in_ready",  32'(in_ready),  32'(mq.size() < 2));
        if (mq.size() > 0) begin
            chk("out_data", 32'(out_data), 32'(mq[0][mpos*DW +: DW]));
            chk("out_idx",  32'(out_idx),  32'(mpos));
            chk("out_last", 32'(out_last), 32'(mpos == L - 1));
        end else begin
            chk("out_last_empty", 32'(out_last), 32'd0);
        end
    endtask

    // One clock with the given inputs; model advances and is compared
    task automatic cyc(input logic iv, input logic [BW-1:0] d, input logic ordy);
        bit acc;
        bit bt;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        acc = iv && (mq.size() < 2);
        bt  = (mq.size() > 0) && ordy;
        @(posedge clk);
        #1;
        if (bt) begin
            mpos++;
            if (mpos == L) begin
                mq.delete(0);
                mpos = 0;
            end
        end
        if (acc) mq.push_back(d);
        check_model();
    endtask

    // Asynchronous reset shortly after an edge, checked before the next edge
    task automatic do_reset(input string nm);
        rst = 1'b1;
        #1;
        chk({nm, "_valid"}, 32'(out_valid), 32'd0);
        chk({nm, "_data"},  32'(out_data),  32'd0);
        chk({nm, "_idx"},   32'(out_idx),   32'd0);
        chk({nm, "_last"},  32'(out_last),  32'd0);
        chk({nm, "_occ"},   32'(occupancy), 32'd0);
        chk({nm, "_rdy"},   32'(in_ready),  32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        mq.delete();
        mpos = 0;
        #1;
        chk({nm, "_rdy_after"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int nacc;
        int vcnt;
        int maxocc;
        int acc_at;
        bit took;
        logic [BW-1:0] blks[3];

        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;

        // Reset state
        #2;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data",  32'(out_data),  32'd0);
        chk("rst_idx",   32'(out_idx),   32'd0);
        chk("rst_last",  32'(out_last),  32'd0);
        chk("rst_occ",   32'(occupancy), 32'd0);
        chk("rst_rdy",   32'(in_ready),  32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("rst_rdy_release", 32'(in_ready), 32'd1);

        // Directed table: single block 1..8, then backpressure 1,0,0,1
        tbl[0] = '{1'b1, 13'h001, 1'b1, 1'b1, 13'h001, 3'd0, 1'b0, 2'd1};
        for (int k = 1; k < 8; k++)
            tbl[k] = '{1'b0, 13'h000, 1'b1, 1'b1, 13'(k + 1), 3'(k), (k == 7), 2'd1};
        tbl[8]  = '{1'b0, 13'h000, 1'b1, 1'b0, 13'h000, 3'd0, 1'b0, 2'd0};
        tbl[9]  = '{1'b1, 13'h011, 1'b0, 1'b1, 13'h011, 3'd0, 1'b0, 2'd1};
        tbl[10] = '{1'b0, 13'h000, 1'b1, 1'b1, 13'h012, 3'd1, 1'b0, 2'd1};
        tbl[11] = '{1'b0, 13'h000, 1'b0, 1'b1, 13'h012, 3'd1, 1'b0, 2'd1};
        tbl[12] = '{1'b0, 13'h000, 1'b0, 1'b1, 13'h012, 3'd1, 1'b0, 2'd1};
        tbl[13] = '{1'b0, 13'h000, 1'b1, 1'b1, 13'h013, 3'd2, 1'b0, 2'd1};
        for (int i = 0; i < 14; i++) begin
            in_valid  = tbl[i].iv;
            in_data   = mkblk(tbl[i].base);
            out_ready = tbl[i].ordy;
            @(posedge clk); #1;
            chk("tbl_valid", 32'(out_valid), 32'(tbl[i].ev));
            chk("tbl_data",  32'(out_data),  32'(tbl[i].ed));
            chk("tbl_idx",   32'(out_idx),   32'(tbl[i].ei));
            chk("tbl_last",  32'(out_last),  32'(tbl[i].el));
            chk("tbl_occ",   32'(occupancy), 32'(tbl[i].eo));
            chk("tbl_rdy",   32'(in_ready),  32'd1);
        end
        in_valid = 1'b0;
        do_reset("rst1");

        // Back-to-back: three blocks, out_ready held high, no idle word
        for (int b = 0; b < 3; b++) blks[b] = rndblk();
        nacc = 0; vcnt = 0; maxocc = 0;
        for (int i = 0; i < 25; i++) begin
            took = (nacc < 3) && in_ready;
            cyc(nacc < 3, blks[nacc < 3 ? nacc : 2], 1'b1);
            if (took) nacc++;
            if (i < 24 && out_valid) vcnt++;
            if (int'(occupancy) > maxocc) maxocc = int'(occupancy);
        end
        chk("b2b_accepts", 32'(nacc), 32'd3);
        chk("b2b_words",   32'(vcnt), 32'd24);
        chk("b2b_maxocc",  32'(maxocc <= 2), 32'd1);

        // Full: two accepted with out_ready low, third waits for release
        for (int b = 0; b < 3; b++) blks[b] = rndblk();
        nacc = 0;
        for (int i = 0; i < 3; i++) begin
            took = in_ready;
            cyc(1'b1, blks[nacc], 1'b0);
            if (took) nacc++;
        end
        chk("full_accepts", 32'(nacc), 32'd2);
        chk("full_rdy",     32'(in_ready), 32'd0);
        acc_at = -1;
        for (int j = 0; j < 24; j++) begin
            took = (nacc < 3) && in_ready;
            cyc(nacc < 3, blks[nacc < 3 ? nacc : 2], 1'b1);
            if (took) begin
                nacc++;
                acc_at = j;
            end
        end
        chk("full_third_at", 32'(acc_at), 32'd8);

        // Reset mid-block: A partially drained, B pending
        cyc(1'b1, rndblk(), 1'b0);
        cyc(1'b1, rndblk(), 1'b0);
        for (int j = 0; j < 4; j++) cyc(1'b0, '0, 1'b1);
        chk("mid_idx_before", 32'(out_idx), 32'd4);
        do_reset("rst2");
        cyc(1'b1, mkblk(13'h0A0), 1'b0);
        chk("mid_restart_idx", 32'(out_idx), 32'd0);
        cyc(1'b0, '0, 1'b1);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++)
            cyc(1'($urandom_range(0, 1)), rndblk(), ($urandom_range(0, 3) != 0));
        for (int i = 0; i < 20; i++) cyc(1'b0, '0, 1'b1);
        chk("drain_occ", 32'(occupancy), 32'd0);

        // LANES=6, DATA_W=16: order, last on 5, gapless wrap to next block
        for (int k = 0; k < 6; k++) b_in_data[k*16 +: 16] = 16'hA000 + 16'(k);
        b_in_valid = 1'b1; b_out_ready = 1'b1;
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            chk("p6_valid", 32'(b_out_valid), 32'd1);
            chk("p6_data",  32'(b_out_data),  32'(16'hA000 + 16'(k)));
            chk("p6_idx",   32'(b_out_idx),   32'(k));
            chk("p6_last",  32'(b_out_last),  32'(k == 5));
            if (k == 5) begin
                for (int m = 0; m < 6; m++) b_in_data[m*16 +: 16] = 16'hB000 + 16'(m);
                b_in_valid = 1'b1;
            end
            @(posedge clk); #1;
            b_in_valid = 1'b0;
        end
        chk("p6_wrap_idx",  32'(b_out_idx),  32'd0);
        chk("p6_wrap_data", 32'(b_out_data), 32'hB000);
        chk("p6_wrap_occ",  32'(b_occupancy), 32'd1);
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
        end
        chk("p6_empty", 32'(b_out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
